// File: rtl/rv_isa_pkg.sv
// RV32I format codes, opcode constants, loader FSM states and the immediate-range helper
// shared by instr_packer and instr_mem_loader.
package rv_isa_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WRITE,
      ST_DONE
   } loaderState_t;

   // True when v is the sign extension of its low 'bits' bits.
   function automatic logic fitsSigned(input logic [31:0] v, input int unsigned bits);
      logic [31:0] hi;
      hi = $signed(v) >>> (bits - 1);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32I field-to-word packer. With LOADER_RANGE_CHECK_EN defined it also
// rejects immediates that do not fit their format; otherwise they are silently truncated.
module instr_packer
   import rv_isa_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        ok
);

   logic fmtOk;
   logic rangeOk;

   always_comb begin
      word  = '0;
      fmtOk = 1'b1;
      case (fmt)
         FMT_R:   word = {funct7, rs2, rs1, funct3, rd, op};
         FMT_I:   word = {imm[11:0], rs1, funct3, rd, op};
         FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         FMT_U:   word = {imm[31:12], rd, op};
         FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: fmtOk = 1'b0;
      endcase
   end

`ifdef LOADER_RANGE_CHECK_EN
   // Branch and jump offsets are halfword-aligned, so bit 0 must be clear.
   always_comb begin
      rangeOk = 1'b1;
      case (fmt)
         FMT_I, FMT_S: rangeOk = fitsSigned(imm, 12);
         FMT_B:        rangeOk = fitsSigned(imm, 13) && !imm[0];
         FMT_J:        rangeOk = fitsSigned(imm, 21) && !imm[0];
         FMT_U:        rangeOk = (imm[11:0] == 12'd0);
         default:      rangeOk = 1'b1;
      endcase
   end
`else
   assign rangeOk = 1'b1;
`endif

   assign ok = fmtOk && rangeOk;

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: accepts instruction fields, packs them and writes consecutive words.
// Optional immediate range checking is enabled by defining LOADER_RANGE_CHECK_EN.
module instr_mem_loader
   import rv_isa_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_op,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TOP_PTR  = '1;

   loaderState_t      state, stateNext;
   logic [ADDR_W-1:0] ptr, ptrNext;
   logic [ADDR_W:0]   cnt, cntNext;
   logic [XLEN-1:0]   wdata, wdataNext;
   logic              errFlag, errNext;
   logic              fullFlag, fullNext;
   logic              lastCap, lastNext;
   logic [31:0]       packWord;
   logic              packOk;

   instr_packer uPacker (
      .fmt    (in_fmt),
      .op     (in_op),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .imm    (in_imm),
      .word   (packWord),
      .ok     (packOk)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= BASE_PTR;
         cnt      <= '0;
         wdata    <= '0;
         errFlag  <= 1'b0;
         fullFlag <= 1'b0;
         lastCap  <= 1'b0;
      end else begin
         state    <= stateNext;
         ptr      <= ptrNext;
         cnt      <= cntNext;
         wdata    <= wdataNext;
         errFlag  <= errNext;
         fullFlag <= fullNext;
         lastCap  <= lastNext;
      end
   end

   always_comb begin
      stateNext = state;
      ptrNext   = ptr;
      cntNext   = cnt;
      wdataNext = wdata;
      errNext   = errFlag;
      fullNext  = fullFlag;
      lastNext  = lastCap;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            done = (state == ST_DONE);
            if (start) begin
               stateNext = ST_ACCEPT;
               ptrNext   = BASE_PTR;
               cntNext   = '0;
               errNext   = 1'b0;
               fullNext  = 1'b0;
            end
         end
         ST_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               if (packOk) begin
                  wdataNext = XLEN'(packWord);
                  lastNext  = in_last;
                  stateNext = ST_WRITE;
               end else begin
                  // Rejected descriptions still honour in_last so a session can end on one.
                  errNext = 1'b1;
                  if (in_last) stateNext = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
            mem_we  = 1'b1;
            busy    = 1'b1;
            cntNext = cnt + 1'b1;
            // The pointer parks on the top word instead of wrapping.
            if (ptr != TOP_PTR) ptrNext = ptr + 1'b1;
            if (lastCap) begin
               stateNext = ST_DONE;
            end else if (ptr == TOP_PTR) begin
               fullNext  = 1'b1;
               stateNext = ST_DONE;
            end else begin
               stateNext = ST_ACCEPT;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   assign mem_addr  = ptr;
   assign mem_wdata = wdata;
   assign count     = cnt;
   assign full      = fullFlag;
   assign err       = errFlag;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised and directed bench for instr_mem_loader against a transaction-level model.
module tb_instr_mem_loader;
   import rv_isa_pkg::*;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_op;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        in_last;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  count;
   logic        busy, done, full, err;

   int checks = 0;
   int errors = 0;

   // Transaction-level model state
   bit          mActive = 1'b0, mDone = 1'b0, mPend = 1'b0, mPendLast = 1'b0;
   bit          mErr = 1'b0, mFull = 1'b0;
   int          mCount = 0;
   logic [31:0] mWdata = '0;

   logic [31:0] memImg [0:DEPTH-1];
   int          wrCycle [0:DEPTH-1];
   int          cyc = 0;
   int          nWrites = 0;
   int          lastWrAddr = -1;

   always #5 clk = ~clk;

   instr_mem_loader #(.XLEN(32), .ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
      .busy(busy), .done(done), .full(full), .err(err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=0x%0h req=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Encoder built from field shifts, independent of concatenation order.
   function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm);
      logic [31:0] w;
      w = 32'(op);
      case (f)
         3'd0: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                     | (32'(rs2) << 20) | (32'(f7) << 25);
         3'd1: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                     | ((imm & 32'hFFF) << 20);
         3'd2: w = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                     | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
         3'd3: w = w | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'hF) << 8)
                     | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                     | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'd1) << 31);
         3'd4: w = w | (32'(rd) << 7) | (imm & 32'hFFFFF000);
         3'd5: w = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                     | (((imm >> 11) & 32'd1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 20) & 32'd1) << 31);
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic bit legal(input logic [2:0] f, input logic [31:0] imm);
      int s;
      s = $signed(imm);
      if (f > 3'd5) return 1'b0;
`ifdef LOADER_RANGE_CHECK_EN
      case (f)
         3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
         3'd3:       return (s >= -4096) && (s <= 4095) && !imm[0];
         3'd5:       return (s >= -1048576) && (s <= 1048575) && !imm[0];
         3'd4:       return imm[11:0] == 12'd0;
         default:    return 1'b1;
      endcase
`else
      return 1'b1 | (s == 0);
`endif
   endfunction

   // Model: one accepted legal description yields one write next cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mActive = 1'b0; mDone = 1'b0; mPend = 1'b0; mPendLast = 1'b0;
         mCount = 0; mErr = 1'b0; mFull = 1'b0; mWdata = '0;
      end else if (mPend) begin
         mPend = 1'b0;
         mCount++;
         if (mPendLast) begin
            mActive = 1'b0; mDone = 1'b1;
         end else if (mCount == DEPTH) begin
            mFull = 1'b1; mActive = 1'b0; mDone = 1'b1;
         end
      end else if (mActive) begin
         if (in_valid) begin
            if (legal(in_fmt, in_imm)) begin
               mPend = 1'b1;
               mPendLast = in_last;
               mWdata = enc(in_fmt, in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
            end else begin
               mErr = 1'b1;
               if (in_last) begin
                  mActive = 1'b0; mDone = 1'b1;
               end
            end
         end
      end else if (start) begin
         mActive = 1'b1; mDone = 1'b0; mCount = 0; mErr = 1'b0; mFull = 1'b0;
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      chk("in_ready", 64'(in_ready), 64'(mActive && !mPend));
      chk("mem_we", 64'(mem_we), 64'(mPend));
      chk("busy", 64'(busy), 64'(mActive));
      chk("done", 64'(done), 64'(mDone));
      chk("full", 64'(full), 64'(mFull));
      chk("err", 64'(err), 64'(mErr));
      chk("count", 64'(count), 64'(mCount));
      chk("mem_addr", 64'(mem_addr), 64'((mCount >= DEPTH) ? DEPTH - 1 : mCount));
      chk("mem_wdata", 64'(mem_wdata), 64'(mWdata));
      if (mem_we) begin
         memImg[mem_addr] = mem_wdata;
         wrCycle[mem_addr] = cyc;
         lastWrAddr = int'(mem_addr);
         nWrites++;
      end
   end

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      int waitN;
      in_fmt = f; in_op = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      waitN = 0;
      forever begin
         @(posedge clk);
         if (in_ready || done) break;
         waitN++;
         if (waitN > 20) begin
            checks++; errors++;
            $display("FAIL handshake_timeout act=no_ready req=ready_within_20 t=%0t", $time);
            break;
         end
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic randSend(input logic last);
      logic [2:0]  f;
      logic [31:0] imm;
      int          m;
      f = ($urandom_range(0, 19) < 18) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      imm = $urandom();
      m = $urandom_range(0, 2);
      if (m == 1) imm = {{20{imm[11]}}, imm[11:1], 1'b0};
      if (m == 2) imm[11:0] = 12'd0;
      if ($urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
      send(f, 7'($urandom()), 3'($urandom()), 7'($urandom()), 5'($urandom()),
           5'($urandom()), 5'($urandom()), imm, last);
   endtask

   task automatic doStart();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chkReset(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_full"}, 64'(full), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, "_count"}, 64'(count), 64'd0);
   endtask

   initial begin
      int wr0;
      start = 1'b0; in_valid = 1'b0; in_fmt = '0; in_op = '0; in_funct3 = '0;
      in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         memImg[i] = 32'hDEADBEEF;
         wrCycle[i] = 0;
      end
      cycles(3);
      rst = 1'b0;

      // Hand-computed encodings pin the model encoder
      chk("enc_addi", 64'(enc(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5)), 64'h00500093);
      chk("enc_beq", 64'(enc(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC)), 64'hFE208EE3);
      chk("enc_jal", 64'(enc(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8)), 64'h008000EF);
      chk("enc_lui", 64'(enc(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000)), 64'h123452B7);

      chkReset("rst");

      // ADDI x1,x0,5 as a one-word session
      doStart();
      send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      chk("addi_we", 64'(mem_we), 64'd1);
      chk("addi_addr", 64'(mem_addr), 64'd0);
      chk("addi_wdata", 64'(mem_wdata), 64'h00500093);
      cycles(1);
      chk("addi_done", 64'(done), 64'd1);
      chk("addi_count", 64'(count), 64'd1);

      // Back-to-back program: ADD, SW, BEQ, JAL, LUI(last)
      doStart();
      send(FMT_R, OPC_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      send(FMT_S, OPC_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
      send(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
      send(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
      send(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
      cycles(1);
      chk("prog_done", 64'(done), 64'd1);
      chk("prog_w0", 64'(memImg[0]), 64'h002081B3);
      chk("prog_w1", 64'(memImg[1]), 64'h0020A423);
      chk("prog_w2", 64'(memImg[2]), 64'hFE208EE3);
      chk("prog_w3", 64'(memImg[3]), 64'h008000EF);
      chk("prog_w4", 64'(memImg[4]), 64'h123452B7);
      for (int i = 1; i < 5; i++)
         chk("prog_spacing", 64'(wrCycle[i] - wrCycle[i-1]), 64'd2);

      // Invalid format, then a B-type with an odd offset
      memImg[0] = 32'hDEADBEEF;
      doStart();
      wr0 = nWrites;
      send(3'd7, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
      cycles(1);
      chk("badfmt_err", 64'(err), 64'd1);
      chk("badfmt_nowrite", 64'(nWrites - wr0), 64'd0);
      chk("badfmt_addr", 64'(mem_addr), 64'd0);
      send(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
      cycles(2);
      chk("odd_b_done", 64'(done), 64'd1);
`ifdef LOADER_RANGE_CHECK_EN
      chk("odd_b_nowrite", 64'(nWrites - wr0), 64'd0);
      chk("odd_b_count", 64'(count), 64'd0);
`else
      chk("odd_b_word", 64'(memImg[0]), 64'h00208163);
      chk("odd_b_count", 64'(count), 64'd1);
`endif

      // Short random sessions
      for (int s = 0; s < 3; s++) begin
         doStart();
         for (int i = 0; i < 40 && !done; i++) randSend($urandom_range(0, 9) == 0);
         if (!done) send(FMT_R, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
         cycles(2);
         chk("short_done", 64'(done), 64'd1);
      end

      // Fill the whole memory without in_last
      doStart();
      wr0 = nWrites;
      for (int i = 0; i < 700 && !done; i++) randSend(1'b0);
      cycles(2);
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_count", 64'(count), 64'd256);
      chk("fill_ready", 64'(in_ready), 64'd0);
      chk("fill_done", 64'(done), 64'd1);
      chk("fill_writes", 64'(nWrites - wr0), 64'd256);
      chk("fill_lastaddr", 64'(lastWrAddr), 64'd255);

      // Reset during the write cycle
      doStart();
      send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd9, 1'b0);
      chk("rstw_we_before", 64'(mem_we), 64'd1);
      #1 rst = 1'b1;
      #1 chkReset("rstw");
      @(posedge clk);
      #1 rst = 1'b0;
      memImg[0] = 32'hDEADBEEF;
      doStart();
      send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      cycles(1);
      chk("rstw_addr", 64'(lastWrAddr), 64'd0);
      chk("rstw_word", 64'(memImg[0]), 64'h00500093);
      chk("rstw_count", 64'(count), 64'd1);

      cycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
